// File: rtl/cplx_div_seq.sv
// Sequential fixed-point complex divider q = a*conj(b)/|b|^2 with valid/ready handshakes.
// Optional macro CPLX_DIV_ROUND_EN: extra guard-bit iteration, round half away from zero.

`ifndef FIXED_POINT_WIDTH
`define FIXED_POINT_WIDTH 13
`endif
`ifndef FRACTION_BITS
`define FRACTION_BITS 8
`endif

module cplx_div_seq #(
  parameter int WIDTH = `FIXED_POINT_WIDTH,
  parameter int FRAC  = `FRACTION_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a_real,
  input  logic signed [WIDTH-1:0] a_imag,
  input  logic signed [WIDTH-1:0] b_real,
  input  logic signed [WIDTH-1:0] b_imag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] result_real,
  output logic signed [WIDTH-1:0] result_imag,
  output logic                    div_by_zero,
  output logic                    overflow
);

`ifdef CPLX_DIV_ROUND_EN
  localparam int ROUND = 1;
`else
  localparam int ROUND = 0;
`endif
  localparam int ITER = WIDTH - 1 + ROUND;
  localparam int PW   = 2*WIDTH + 2;
  localparam int WW   = 3*WIDTH + FRAC + 2;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic signed [WIDTH-1:0] MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MAXNEG = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

  state_t                  state_q;
  logic signed [WIDTH-1:0] aReal_q, aImag_q, bReal_q, bImag_q;
  logic                    signReal_q, signImag_q;
  logic                    ovfReal_q, ovfImag_q;
  logic [WW-1:0]           remReal_q, remImag_q, divisor_q;
  logic [ITER-1:0]         quoReal_q, quoImag_q;
  logic [CW-1:0]           cnt_q;
  logic                    outValid_q, divZero_q, overflow_q;
  logic signed [WIDTH-1:0] resReal_q, resImag_q;

  logic signed [PW-1:0]    prodNr, prodNi, prodD;
  logic [PW-1:0]           magNr, magNi, dVal;
  logic                    ovfR, ovfI, dZero;
  logic signed [WIDTH-1:0] zeroReal, zeroImag;

  // PREP arithmetic: numerators, |b|^2, magnitudes and per-component overflow
  always_comb begin
    prodNr   = PW'(aReal_q) * PW'(bReal_q) + PW'(aImag_q) * PW'(bImag_q);
    prodNi   = PW'(aImag_q) * PW'(bReal_q) - PW'(aReal_q) * PW'(bImag_q);
    prodD    = PW'(bReal_q) * PW'(bReal_q) + PW'(bImag_q) * PW'(bImag_q);
    dVal     = $unsigned(prodD);
    magNr    = prodNr[PW-1] ? $unsigned(-prodNr) : $unsigned(prodNr);
    magNi    = prodNi[PW-1] ? $unsigned(-prodNi) : $unsigned(prodNi);
    dZero    = (dVal == '0);
    ovfR     = (WW'(magNr) << FRAC) >= (WW'(dVal) << (WIDTH-1));
    ovfI     = (WW'(magNi) << FRAC) >= (WW'(dVal) << (WIDTH-1));
    zeroReal = aReal_q[WIDTH-1] ? MAXNEG : ((aReal_q != '0) ? MAXPOS : '0);
    zeroImag = aImag_q[WIDTH-1] ? MAXNEG : ((aImag_q != '0) ? MAXPOS : '0);
  end

  logic          geReal, geImag;
  logic [WW-1:0] remRealNext, remImagNext;

  always_comb begin
    geReal      = remReal_q >= divisor_q;
    geImag      = remImag_q >= divisor_q;
    remRealNext = geReal ? remReal_q - divisor_q : remReal_q;
    remImagNext = geImag ? remImag_q - divisor_q : remImag_q;
  end

  logic [WIDTH:0]          fixMagReal, fixMagImag;
  logic                    satReal, satImag;
  logic signed [WIDTH-1:0] finReal, finImag;

  // Final magnitude (optionally rounded), saturation and sign restore
  always_comb begin
    fixMagReal = (WIDTH+1)'(quoReal_q);
    fixMagImag = (WIDTH+1)'(quoImag_q);
`ifdef CPLX_DIV_ROUND_EN
    fixMagReal = ((WIDTH+1)'(quoReal_q) + (WIDTH+1)'(1)) >> 1;
    fixMagImag = ((WIDTH+1)'(quoImag_q) + (WIDTH+1)'(1)) >> 1;
`endif
    satReal = ovfReal_q | (|fixMagReal[WIDTH:WIDTH-1]);
    satImag = ovfImag_q | (|fixMagImag[WIDTH:WIDTH-1]);
    finReal = satReal ? (signReal_q ? MAXNEG : MAXPOS)
                      : (signReal_q ? -$signed(fixMagReal[WIDTH-1:0])
                                    :  $signed(fixMagReal[WIDTH-1:0]));
    finImag = satImag ? (signImag_q ? MAXNEG : MAXPOS)
                      : (signImag_q ? -$signed(fixMagImag[WIDTH-1:0])
                                    :  $signed(fixMagImag[WIDTH-1:0]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      aReal_q    <= '0;
      aImag_q    <= '0;
      bReal_q    <= '0;
      bImag_q    <= '0;
      signReal_q <= 1'b0;
      signImag_q <= 1'b0;
      ovfReal_q  <= 1'b0;
      ovfImag_q  <= 1'b0;
      remReal_q  <= '0;
      remImag_q  <= '0;
      divisor_q  <= '0;
      quoReal_q  <= '0;
      quoImag_q  <= '0;
      cnt_q      <= '0;
      outValid_q <= 1'b0;
      divZero_q  <= 1'b0;
      overflow_q <= 1'b0;
      resReal_q  <= '0;
      resImag_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            aReal_q <= a_real;
            aImag_q <= a_imag;
            bReal_q <= b_real;
            bImag_q <= b_imag;
            state_q <= PREP;
          end
        end
        PREP: begin
          signReal_q <= prodNr[PW-1];
          signImag_q <= prodNi[PW-1];
          if (dZero) begin
            resReal_q  <= zeroReal;
            resImag_q  <= zeroImag;
            divZero_q  <= 1'b1;
            overflow_q <= 1'b1;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            ovfReal_q <= ovfR;
            ovfImag_q <= ovfI;
            remReal_q <= WW'(magNr) << (FRAC + ROUND);
            remImag_q <= WW'(magNi) << (FRAC + ROUND);
            divisor_q <= WW'(dVal) << (ITER - 1);
            quoReal_q <= '0;
            quoImag_q <= '0;
            cnt_q     <= '0;
            state_q   <= DIV;
          end
        end
        // ITER shift-subtract steps, then one cycle to fix sign and register the result
        DIV: begin
          if (cnt_q == CW'(ITER)) begin
            resReal_q  <= finReal;
            resImag_q  <= finImag;
            overflow_q <= satReal | satImag;
            divZero_q  <= 1'b0;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            remReal_q <= remRealNext;
            remImag_q <= remImagNext;
            quoReal_q <= {quoReal_q[ITER-2:0], geReal};
            quoImag_q <= {quoImag_q[ITER-2:0], geImag};
            divisor_q <= divisor_q >> 1;
            cnt_q     <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            divZero_q  <= 1'b0;
            overflow_q <= 1'b0;
            resReal_q  <= '0;
            resImag_q  <= '0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE) && !rst;
  assign out_valid   = outValid_q;
  assign result_real = resReal_q;
  assign result_imag = resImag_q;
  assign div_by_zero = divZero_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_cplx_div_seq.sv
// Directed self-checking bench for cplx_div_seq at WIDTH=13, FRAC=8 (1.0 = 256).
// Expectations follow CPLX_DIV_ROUND_EN when the macro is defined for the build.

module tb_cplx_div_seq;
  localparam int W = 13;

`ifdef CPLX_DIV_ROUND_EN
  localparam int LAT = W + 2;
  localparam logic signed [W-1:0] Q_TWO_THIRDS = 13'sd171;
`else
  localparam int LAT = W + 1;
  localparam logic signed [W-1:0] Q_TWO_THIRDS = 13'sd170;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid, in_ready;
  logic signed [W-1:0] a_real, a_imag, b_real, b_imag;
  logic                out_valid, out_ready;
  logic signed [W-1:0] result_real, result_imag;
  logic                div_by_zero, overflow;

  int tests = 0;
  int fails = 0;

  cplx_div_seq #(.WIDTH(W), .FRAC(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_real(result_real), .result_imag(result_imag),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Presents one operand set, waits for the result and leaves it pending in DONE
  task automatic runOp(input logic signed [W-1:0] ar, ai, br, bi,
                       output logic signed [W-1:0] rr, ri,
                       output logic dz, ov, output int lat);
    int n;
    @(negedge clk);
    a_real = ar; a_imag = ai; b_real = br; b_imag = bi;
    in_valid = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
    end
    rr = result_real; ri = result_imag; dz = div_by_zero; ov = overflow;
  endtask

  task automatic finishOp();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_real = '0; a_imag = '0; b_real = '0; b_imag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_handshake: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
    end
    tests++;
    if (result_real !== 13'sd0 || result_imag !== 13'sd0 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: res=(%0d,%0d) dz=%b ov=%b, required (0,0) 0 0",
               result_real, result_imag, div_by_zero, overflow);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_idle_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic signed [W-1:0] rr, ri;
    logic dz, ov;
    int lat;
    runOp(13'sd512, 13'sd1024, 13'sd256, 13'sd256, rr, ri, dz, ov, lat);
    tests++;
    if (lat !== LAT) begin
      fails++;
      $display("[TB] FAIL basic_latency: %0d edges, required %0d", lat, LAT);
    end
    tests++;
    if (rr !== 13'sd768 || ri !== 13'sd256 || dz !== 1'b0 || ov !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_3p1j: (%0d,%0d) dz=%b ov=%b, required (768,256) 0 0", rr, ri, dz, ov);
    end
    finishOp();
    // (-2+1j)/(1j) = 1+2j
    runOp(-13'sd512, 13'sd256, 13'sd0, 13'sd256, rr, ri, dz, ov, lat);
    tests++;
    if (rr !== 13'sd256 || ri !== 13'sd512 || dz !== 1'b0 || ov !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_imag_div: (%0d,%0d) dz=%b ov=%b, required (256,512) 0 0", rr, ri, dz, ov);
    end
    finishOp();
    // 1/(-2j) = 0.5j
    runOp(13'sd256, 13'sd0, 13'sd0, -13'sd512, rr, ri, dz, ov, lat);
    tests++;
    if (rr !== 13'sd0 || ri !== 13'sd128 || ov !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_neg_imag_b: (%0d,%0d) ov=%b, required (0,128) 0", rr, ri, ov);
    end
    finishOp();
    runOp(13'sd0, 13'sd0, 13'sd300, -13'sd7, rr, ri, dz, ov, lat);
    tests++;
    if (rr !== 13'sd0 || ri !== 13'sd0 || dz !== 1'b0 || ov !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_numerator: (%0d,%0d) dz=%b ov=%b, required (0,0) 0 0", rr, ri, dz, ov);
    end
    finishOp();
  endtask

  task automatic test_truncation();
    logic signed [W-1:0] rr, ri;
    logic dz, ov;
    int lat;
    runOp(13'sd512, 13'sd0, 13'sd768, 13'sd0, rr, ri, dz, ov, lat);
    tests++;
    if (rr !== Q_TWO_THIRDS || ri !== 13'sd0 || ov !== 1'b0 || lat !== LAT) begin
      fails++;
      $display("[TB] FAIL two_thirds: (%0d,%0d) ov=%b lat=%0d, required (%0d,0) 0 %0d",
               rr, ri, ov, lat, Q_TWO_THIRDS, LAT);
    end
    finishOp();
    runOp(-13'sd512, 13'sd0, 13'sd768, 13'sd0, rr, ri, dz, ov, lat);
    tests++;
    if (rr !== -Q_TWO_THIRDS || ri !== 13'sd0 || ov !== 1'b0) begin
      fails++;
      $display("[TB] FAIL neg_two_thirds: (%0d,%0d) ov=%b, required (%0d,0) 0", rr, ri, ov, -Q_TWO_THIRDS);
    end
    finishOp();
  endtask

  task automatic test_overflow();
    logic signed [W-1:0] rr, ri;
    logic dz, ov;
    int lat;
    runOp(13'sd4000, -13'sd4000, 13'sd1, 13'sd0, rr, ri, dz, ov, lat);
    tests++;
    if (rr !== 13'sd4095 || ri !== -13'sd4095 || ov !== 1'b1 || dz !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ovf_saturate: (%0d,%0d) dz=%b ov=%b, required (4095,-4095) 0 1", rr, ri, dz, ov);
    end
    finishOp();
    runOp(13'sd4095, 13'sd0, 13'sd256, 13'sd0, rr, ri, dz, ov, lat);
    tests++;
    if (rr !== 13'sd4095 || ri !== 13'sd0 || ov !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ovf_edge_max: (%0d,%0d) ov=%b, required (4095,0) 0", rr, ri, ov);
    end
    finishOp();
    runOp(-13'sd4096, 13'sd0, 13'sd256, 13'sd0, rr, ri, dz, ov, lat);
    tests++;
    if (rr !== -13'sd4095 || ri !== 13'sd0 || ov !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ovf_edge_min: (%0d,%0d) ov=%b, required (-4095,0) 1", rr, ri, ov);
    end
    finishOp();
  endtask

  task automatic test_div_by_zero();
    logic signed [W-1:0] rr, ri;
    logic dz, ov;
    int lat;
    runOp(13'sd256, 13'sd0, 13'sd0, 13'sd0, rr, ri, dz, ov, lat);
    tests++;
    if (rr !== 13'sd4095 || ri !== 13'sd0 || dz !== 1'b1 || ov !== 1'b1) begin
      fails++;
      $display("[TB] FAIL dbz_pos: (%0d,%0d) dz=%b ov=%b, required (4095,0) 1 1", rr, ri, dz, ov);
    end
    finishOp();
    runOp(13'sd256, 13'sd0, 13'sd256, 13'sd0, rr, ri, dz, ov, lat);
    tests++;
    if (rr !== 13'sd256 || ri !== 13'sd0 || dz !== 1'b0 || ov !== 1'b0) begin
      fails++;
      $display("[TB] FAIL dbz_flags_clear: (%0d,%0d) dz=%b ov=%b, required (256,0) 0 0", rr, ri, dz, ov);
    end
    finishOp();
    runOp(-13'sd5, 13'sd9, 13'sd0, 13'sd0, rr, ri, dz, ov, lat);
    tests++;
    if (rr !== -13'sd4095 || ri !== 13'sd4095 || dz !== 1'b1 || ov !== 1'b1 || lat >= LAT) begin
      fails++;
      $display("[TB] FAIL dbz_signs: (%0d,%0d) dz=%b ov=%b lat=%0d, required (-4095,4095) 1 1 lat<%0d",
               rr, ri, dz, ov, lat, LAT);
    end
    finishOp();
  endtask

  task automatic test_back_to_back();
    logic signed [W-1:0] rr, ri;
    logic dz, ov;
    int lat;
    int bad;
    runOp(13'sd512, 13'sd1024, 13'sd256, 13'sd256, rr, ri, dz, ov, lat);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result_real !== 13'sd768 ||
          result_imag !== 13'sd256 || overflow !== 1'b0 || div_by_zero !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("[TB] FAIL hold_stable: %0d unstable cycles, required 0 (last res=(%0d,%0d) ov=%b in_ready=%b)",
               bad, result_real, result_imag, overflow, in_ready);
    end
    // Release the result and present the next operand set in the same cycle
    @(negedge clk);
    out_ready = 1'b1;
    a_real = 13'sd512; a_imag = 13'sd0; b_real = 13'sd768; b_imag = 13'sd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_ready: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
    end
    tests++;
    if (lat !== LAT || result_real !== Q_TWO_THIRDS || result_imag !== 13'sd0) begin
      fails++;
      $display("[TB] FAIL b2b_result: (%0d,%0d) lat=%0d, required (%0d,0) %0d",
               result_real, result_imag, lat, Q_TWO_THIRDS, LAT);
    end
    finishOp();
  endtask

  task automatic test_reset_abort();
    logic signed [W-1:0] rr, ri;
    logic dz, ov;
    int lat;
    int seen;
    @(negedge clk);
    a_real = 13'sd512; a_imag = 13'sd1024; b_real = 13'sd256; b_imag = 13'sd256;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_in_reset: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL abort_ready: in_ready=%b, required 1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 if (out_valid !== 1'b0) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("[TB] FAIL abort_no_stale: out_valid high %0d cycles, required 0", seen);
    end
    runOp(13'sd512, 13'sd1024, 13'sd256, 13'sd256, rr, ri, dz, ov, lat);
    tests++;
    if (rr !== 13'sd768 || ri !== 13'sd256 || ov !== 1'b0 || lat !== LAT) begin
      fails++;
      $display("[TB] FAIL abort_fresh_op: (%0d,%0d) ov=%b lat=%0d, required (768,256) 0 %0d", rr, ri, ov, lat, LAT);
    end
    finishOp();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_truncation();
    test_overflow();
    test_div_by_zero();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
